// File: rtl/conv2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : conv2_pkg                                                     |
// | Purpose    : Shared types and default dimensions for the second            |
// |              convolution layer scheduler (2 ch x 14x14 in, 2 kernels of    |
// |              2x5x5, 2 maps of 10x10 out).                                  |
// | Contents   : conv2_state_e FSM encoding, default dimension constants,      |
// |              index-width helper.                                           |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package conv2_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } conv2_state_e;

  localparam int CONV2_IN_DIM  = 14;
  localparam int CONV2_K_DIM   = 5;
  localparam int CONV2_N_CH    = 2;
  localparam int CONV2_N_KER   = 2;
  localparam int CONV2_OUT_DIM = CONV2_IN_DIM - CONV2_K_DIM + 1;

  // Width of an index counting 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv2_index_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : conv2_index_counter                                           |
// | Purpose    : Nested ker/row/col/ch loop counter (ch innermost).            |
// | Ports      : clk, rst (async, active high)                                 |
// |              clear   - force all indices to 0                              |
// |              inc_ch  - advance to the next input channel                   |
// |              inc_pix - ch to 0 and advance col/row/ker with wrap           |
// |              ker,row,col,ch - current indices                              |
// |              last_ch  - ch is the final channel                            |
// |              last_pix - ker/row/col address the final output pixel         |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module conv2_index_counter
  import conv2_pkg::*;
#(
  parameter int OUT_DIM = CONV2_OUT_DIM,
  parameter int N_CH    = CONV2_N_CH,
  parameter int N_KER   = CONV2_N_KER,
  parameter int CW      = $clog2(CONV2_OUT_DIM),
  parameter int CHW     = idx_width(CONV2_N_CH),
  parameter int KW      = idx_width(CONV2_N_KER)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           inc_ch,
  input  logic           inc_pix,
  output logic [KW-1:0]  ker,
  output logic [CW-1:0]  row,
  output logic [CW-1:0]  col,
  output logic [CHW-1:0] ch,
  output logic           last_ch,
  output logic           last_pix
);

  logic last_col;
  logic last_row;
  logic last_ker;

  assign last_col = (col == CW'(OUT_DIM - 1));
  assign last_row = (row == CW'(OUT_DIM - 1));
  assign last_ker = (ker == KW'(N_KER - 1));
  assign last_ch  = (ch == CHW'(N_CH - 1));
  assign last_pix = last_ker && last_row && last_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ker <= '0;
      row <= '0;
      col <= '0;
      ch  <= '0;
    end else if (clear) begin
      ker <= '0;
      row <= '0;
      col <= '0;
      ch  <= '0;
    end else if (inc_pix) begin
      ch <= '0;
      if (last_col) begin
        col <= '0;
        if (last_row) begin
          row <= '0;
          ker <= last_ker ? '0 : ker + KW'(1);
        end else begin
          row <= row + CW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
    end else if (inc_ch) begin
      ch <= ch + CHW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv2_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : conv2_scheduler                                               |
// | Purpose    : Time-multiplexes one 5x5 window-convolution unit over the     |
// |              whole conv2 layer: per output pixel, one window request per   |
// |              input channel, channel partials summed, pixel written out.    |
// | Ports      : clk, rst (async, active high), start / busy / done            |
// |              win_valid/win_ready + win_ker/ch/row/col : window request     |
// |              res_valid/res_data : partial result of outstanding request   |
// |              wr_en + wr_ker/row/col/data : output pixel write             |
// | Options    : CONV2_SCHED_RELU_EN - apply two's-complement ReLU to wr_data  |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module conv2_scheduler
  import conv2_pkg::*;
#(
  parameter  int BITWIDTH = 32,
  parameter  int IN_DIM   = CONV2_IN_DIM,
  parameter  int K_DIM    = CONV2_K_DIM,
  parameter  int N_CH     = CONV2_N_CH,
  parameter  int N_KER    = CONV2_N_KER,
  localparam int OUT_DIM  = IN_DIM - K_DIM + 1,
  localparam int CW       = $clog2(OUT_DIM),
  localparam int CHW      = idx_width(N_CH),
  localparam int KW       = idx_width(N_KER)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [KW-1:0]       win_ker,
  output logic [CHW-1:0]      win_ch,
  output logic [CW-1:0]       win_row,
  output logic [CW-1:0]       win_col,
  input  logic                res_valid,
  input  logic [BITWIDTH-1:0] res_data,
  output logic                wr_en,
  output logic [KW-1:0]       wr_ker,
  output logic [CW-1:0]       wr_row,
  output logic [CW-1:0]       wr_col,
  output logic [BITWIDTH-1:0] wr_data
);

  conv2_state_e state;
  conv2_state_e state_next;

  logic clear;
  logic inc_ch;
  logic inc_pix;

  logic [KW-1:0]       ker;
  logic [CW-1:0]       row;
  logic [CW-1:0]       col;
  logic [CHW-1:0]      ch;
  logic                last_ch;
  logic                last_pix;

  logic [BITWIDTH-1:0] acc;
  logic [BITWIDTH-1:0] acc_sum;
  logic [BITWIDTH-1:0] pix_value;
  // Remembers whether the pixel now being written was the final one,
  // because the counter has already moved past it during WRITE.
  logic                last_r;

  // The counter advances to the next pixel on the WAIT->WRITE edge, so that
  // during WRITE it already holds the indices the following ISSUE needs.
  conv2_index_counter #(
    .OUT_DIM (OUT_DIM),
    .N_CH    (N_CH),
    .N_KER   (N_KER),
    .CW      (CW),
    .CHW     (CHW),
    .KW      (KW)
  ) u_idx (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .inc_ch   (inc_ch),
    .inc_pix  (inc_pix),
    .ker      (ker),
    .row      (row),
    .col      (col),
    .ch       (ch),
    .last_ch  (last_ch),
    .last_pix (last_pix)
  );

  assign acc_sum = (ch == '0) ? res_data : acc + res_data;

`ifdef CONV2_SCHED_RELU_EN
  assign pix_value = acc_sum[BITWIDTH-1] ? '0 : acc_sum;
`else
  assign pix_value = acc_sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    inc_ch     = 1'b0;
    inc_pix    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ISSUE;
          clear      = 1'b1;
        end
      end
      ISSUE: begin
        if (win_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (res_valid) begin
          if (last_ch) begin
            state_next = WRITE;
            inc_pix    = 1'b1;
          end else begin
            state_next = ISSUE;
            inc_ch     = 1'b1;
          end
        end
      end
      WRITE: begin
        state_next = last_r ? DONE : ISSUE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered outputs: strobes follow the next state so they line up with
  // the state they describe; index fields only load when a strobe begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      win_valid <= 1'b0;
      wr_en     <= 1'b0;
      win_ker   <= '0;
      win_ch    <= '0;
      win_row   <= '0;
      win_col   <= '0;
      wr_ker    <= '0;
      wr_row    <= '0;
      wr_col    <= '0;
      wr_data   <= '0;
      acc       <= '0;
      last_r    <= 1'b0;
    end else begin
      busy      <= (state_next != IDLE);
      done      <= (state_next == DONE);
      win_valid <= (state_next == ISSUE);
      wr_en     <= (state_next == WRITE);

      if (state == IDLE && start) begin
        win_ker <= '0;
        win_ch  <= '0;
        win_row <= '0;
        win_col <= '0;
      end else if (state == WAIT && res_valid && !last_ch) begin
        win_ch <= ch + CHW'(1);
      end else if (state == WRITE && !last_r) begin
        win_ker <= ker;
        win_ch  <= ch;
        win_row <= row;
        win_col <= col;
      end

      if (state == WAIT && res_valid) begin
        acc <= acc_sum;
        if (last_ch) begin
          wr_ker  <= ker;
          wr_row  <= row;
          wr_col  <= col;
          wr_data <= pix_value;
          last_r  <= last_pix;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv2_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_conv2_scheduler                                            |
// | Purpose    : Self-checking bench for conv2_scheduler. A cycle driver acts  |
// |              as the window datapath and logs requests, partials, writes   |
// |              and done pulses; each test task compares the logs against a  |
// |              loop-order / arithmetic reference model.                      |
// | Options    : CONV2_SCHED_RELU_EN - expect ReLU on written pixels           |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_conv2_scheduler;

  localparam int NPIX = 200;
  localparam int NREQ = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, win_valid, wr_en;
  logic        win_ready = 1'b0;
  logic        res_valid = 1'b0;
  logic [31:0] res_data = '0;
  logic [0:0]  win_ker, win_ch, wr_ker;
  logic [3:0]  win_row, win_col, wr_row, wr_col;
  logic [31:0] wr_data;

  conv2_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .win_valid(win_valid), .win_ready(win_ready), .win_ker(win_ker),
    .win_ch(win_ch), .win_row(win_row), .win_col(win_col),
    .res_valid(res_valid), .res_data(res_data), .wr_en(wr_en),
    .wr_ker(wr_ker), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct { int ker; int ch; int row; int col; } req_t;
  typedef struct { int ker; int row; int col; logic [31:0] data; } wr_t;

  req_t        req_q[$];
  wr_t         wr_q[$];
  logic [31:0] part_q[$];
  logic [31:0] force_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt, done_cyc, first_issue, last_write, stable_err, busy_err;
  bit timeout, busy_after_start;

  // ---------------- reference model ----------------
  function automatic int m_ker(input int p); return p / 100;       endfunction
  function automatic int m_row(input int p); return (p / 10) % 10; endfunction
  function automatic int m_col(input int p); return p % 10;        endfunction

  function automatic logic [31:0] m_pixel(input int j);
    logic [31:0] s;
    s = part_q[2*j] + part_q[2*j+1];
`ifdef CONV2_SCHED_RELU_EN
    if (s[31]) s = 32'd0;
`endif
    return s;
  endfunction

  // ---------------- datapath driver (logs only) ----------------
  task automatic drive_pass(input int stall_max, input bit rnd, input bit spurious,
                            input int abort_at, input int budget);
    int stall = 0;
    bit have_req = 0;
    req_t held;
    bit pend_v = 0;
    logic [31:0] pend = '0;
    logic [31:0] d;
    int tail = 0;
    req_q.delete(); wr_q.delete(); part_q.delete();
    done_cnt = 0; done_cyc = -1; first_issue = -1; last_write = -1;
    stable_err = 0; busy_err = 0; timeout = 0;
    @(negedge clk);
    start = 1'b1;
    for (int it = 0; ; it++) begin
      @(negedge clk);
      cyc++;
      start     = 1'b0;
      res_valid = 1'b0;
      res_data  = $urandom;
      win_ready = 1'b0;
      if (it == 0) busy_after_start = busy;
      if (spurious && busy && (it % 7 == 3)) start = 1'b1;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (wr_en) begin
        wr_q.push_back('{int'(wr_ker), int'(wr_row), int'(wr_col), wr_data});
        last_write = cyc;
      end
      if ((win_valid || wr_en || done) && !busy) busy_err++;
      if (pend_v) begin
        res_valid = 1'b1; res_data = pend; pend_v = 0;
      end
      if (win_valid) begin
        if (first_issue < 0) first_issue = cyc;
        if (!have_req) begin
          have_req = 1;
          held = '{int'(win_ker), int'(win_ch), int'(win_row), int'(win_col)};
          stall = stall_max;
        end else if (held.ker != int'(win_ker) || held.ch != int'(win_ch) ||
                     held.row != int'(win_row) || held.col != int'(win_col)) begin
          stable_err++;
        end
        if (stall > 0) begin
          stall--;
        end else begin
          win_ready = 1'b1;
          req_q.push_back(held);
          have_req = 0;
          if (force_q.size() > 0) d = force_q.pop_front();
          else if (rnd) d = $urandom;
          else d = 32'd1;
          part_q.push_back(d);
          pend = d; pend_v = 1;
        end
      end
      if (spurious && !res_valid && (wr_en || (win_valid && !win_ready))) begin
        res_valid = 1'b1; res_data = $urandom;
      end
      if (abort_at > 0 && wr_q.size() == abort_at) break;
      if (done_cnt > 0) tail++;
      if (tail > 3) break;
      if (it >= budget) begin timeout = 1; break; end
    end
    win_ready = 1'b0; res_valid = 1'b0; start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int bad = 0;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, win_valid, win_ker, win_ch, win_row, win_col, wr_en,
         wr_ker, wr_row, wr_col, wr_data} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got busy=%b done=%b wv=%b wr_en=%b wr_data=%h, want all 0",
                         busy, done, win_valid, wr_en, wr_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (win_valid !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL reset_idle: %0d active cycles, want 0", bad); end
  endtask

  task automatic test_full_pass;
    int bad_req = 0, bad_wr = 0;
    drive_pass(0, 0, 0, 0, 5000);
    n_cmp++; if (timeout) begin n_fail++; $display("FAIL full_timeout: pass did not finish"); end
    n_cmp++; if (req_q.size() != NREQ) begin n_fail++; $display("FAIL full_req_count: got %0d want %0d", req_q.size(), NREQ); end
    n_cmp++; if (wr_q.size() != NPIX) begin n_fail++; $display("FAIL full_wr_count: got %0d want %0d", wr_q.size(), NPIX); end
    for (int i = 0; i < req_q.size() && i < NREQ; i++)
      if (req_q[i].ker != m_ker(i/2) || req_q[i].ch != i%2 ||
          req_q[i].row != m_row(i/2) || req_q[i].col != m_col(i/2)) bad_req++;
    n_cmp++; if (bad_req != 0) begin n_fail++; $display("FAIL full_req_order: %0d out-of-order requests, want 0", bad_req); end
    for (int j = 0; j < wr_q.size() && j < NPIX; j++)
      if (wr_q[j].ker != m_ker(j) || wr_q[j].row != m_row(j) ||
          wr_q[j].col != m_col(j) || wr_q[j].data !== 32'd2) bad_wr++;
    n_cmp++; if (bad_wr != 0) begin n_fail++; $display("FAIL full_wr_values: %0d bad writes, want 0 (data 2)", bad_wr); end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL full_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (done_cyc != last_write + 1) begin n_fail++; $display("FAIL full_done_timing: done at %0d, last write %0d", done_cyc, last_write); end
    n_cmp++; if (last_write - first_issue + 1 != 1000) begin n_fail++; $display("FAIL full_cycles: got %0d want 1000", last_write - first_issue + 1); end
    n_cmp++; if (busy_after_start !== 1'b1) begin n_fail++; $display("FAIL full_busy_start: got %b want 1", busy_after_start); end
    n_cmp++; if (busy_err != 0) begin n_fail++; $display("FAIL full_busy_gap: %0d cycles active without busy", busy_err); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_backpressure;
    int bad_req = 0, bad_wr = 0;
    drive_pass(3, 1, 0, 0, 8000);
    n_cmp++; if (stable_err != 0) begin n_fail++; $display("FAIL bp_stable: %0d field changes while stalled, want 0", stable_err); end
    n_cmp++; if (req_q.size() != NREQ) begin n_fail++; $display("FAIL bp_req_count: got %0d want %0d", req_q.size(), NREQ); end
    for (int i = 0; i < req_q.size() && i < NREQ; i++)
      if (req_q[i].ker != m_ker(i/2) || req_q[i].ch != i%2 ||
          req_q[i].row != m_row(i/2) || req_q[i].col != m_col(i/2)) bad_req++;
    n_cmp++; if (bad_req != 0) begin n_fail++; $display("FAIL bp_req_order: %0d bad requests, want 0", bad_req); end
    n_cmp++; if (wr_q.size() != NPIX) begin n_fail++; $display("FAIL bp_wr_count: got %0d want %0d", wr_q.size(), NPIX); end
    for (int j = 0; j < wr_q.size() && j < NPIX && 2*j+1 < part_q.size(); j++)
      if (wr_q[j].ker != m_ker(j) || wr_q[j].row != m_row(j) ||
          wr_q[j].col != m_col(j) || wr_q[j].data !== m_pixel(j)) bad_wr++;
    n_cmp++; if (bad_wr != 0) begin n_fail++; $display("FAIL bp_wr_values: %0d bad writes, want 0", bad_wr); end
  endtask

  task automatic test_accum_wrap;
    logic [31:0] exp1;
    int bad_wr = 0;
`ifdef CONV2_SCHED_RELU_EN
    exp1 = 32'd0;
`else
    exp1 = 32'hFFFF_FFFD;
`endif
    force_q.delete();
    force_q.push_back(32'hFFFF_FFFF); force_q.push_back(32'h0000_0002);
    force_q.push_back(32'd5);         force_q.push_back(32'hFFFF_FFF8);
    drive_pass(0, 1, 0, 0, 5000);
    n_cmp++;
    if (wr_q.size() < 2) begin
      n_fail++; $display("FAIL acc_writes: got %0d writes want >=2", wr_q.size());
    end else begin
      n_cmp++;
      if (wr_q[0].data !== 32'h0000_0001) begin n_fail++; $display("FAIL acc_wrap: got %h want 00000001", wr_q[0].data); end
      if (wr_q[1].data !== exp1) begin n_fail++; $display("FAIL acc_signed: got %h want %h", wr_q[1].data, exp1); end
    end
    for (int j = 0; j < wr_q.size() && 2*j+1 < part_q.size(); j++)
      if (wr_q[j].data !== m_pixel(j)) bad_wr++;
    n_cmp++; if (bad_wr != 0 || wr_q.size() != NPIX) begin n_fail++; $display("FAIL acc_random: %0d bad of %0d writes", bad_wr, wr_q.size()); end
  endtask

  task automatic test_spurious;
    int bad_wr = 0;
    drive_pass(0, 1, 1, 0, 5000);
    n_cmp++; if (wr_q.size() != NPIX) begin n_fail++; $display("FAIL spur_wr_count: got %0d want %0d", wr_q.size(), NPIX); end
    for (int j = 0; j < wr_q.size() && j < NPIX && 2*j+1 < part_q.size(); j++)
      if (wr_q[j].ker != m_ker(j) || wr_q[j].row != m_row(j) ||
          wr_q[j].col != m_col(j) || wr_q[j].data !== m_pixel(j)) bad_wr++;
    n_cmp++; if (bad_wr != 0) begin n_fail++; $display("FAIL spur_wr_values: %0d bad writes, want 0", bad_wr); end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL spur_done: got %0d want 1", done_cnt); end
    n_cmp++; if (last_write - first_issue + 1 != 1000) begin n_fail++; $display("FAIL spur_cycles: got %0d want 1000", last_write - first_issue + 1); end
  endtask

  task automatic test_reset_mid;
    int bad_wr = 0, late_done = 0;
    drive_pass(0, 1, 0, 57, 5000);
    n_cmp++; if (wr_q.size() != 57 || done_cnt != 0) begin n_fail++; $display("FAIL mid_prefix: writes %0d done %0d, want 57 and 0", wr_q.size(), done_cnt); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, win_valid, win_ker, win_ch, win_row, win_col, wr_en,
         wr_ker, wr_row, wr_col, wr_data} !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: busy=%b wv=%b wr_en=%b wr_data=%h, want all 0", busy, win_valid, wr_en, wr_data);
    end
    @(negedge clk); rst = 1'b0;
    repeat (5) begin @(negedge clk); if (done || busy) late_done++; end
    n_cmp++; if (late_done != 0) begin n_fail++; $display("FAIL mid_after_reset: %0d active cycles, want 0", late_done); end
    drive_pass(0, 1, 0, 0, 5000);
    n_cmp++;
    if (req_q.size() == 0 || req_q[0].ker != 0 || req_q[0].ch != 0 || req_q[0].row != 0 || req_q[0].col != 0) begin
      n_fail++; $display("FAIL mid_first_req: got %0d requests / first not (0,0,0,0)", req_q.size());
    end
    for (int j = 0; j < wr_q.size() && j < NPIX && 2*j+1 < part_q.size(); j++)
      if (wr_q[j].ker != m_ker(j) || wr_q[j].row != m_row(j) ||
          wr_q[j].col != m_col(j) || wr_q[j].data !== m_pixel(j)) bad_wr++;
    n_cmp++; if (bad_wr != 0 || wr_q.size() != NPIX) begin n_fail++; $display("FAIL mid_full_pass: %0d bad of %0d writes, want 0 of %0d", bad_wr, wr_q.size(), NPIX); end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL mid_done: got %0d want 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_backpressure();
    test_accum_wrap();
    test_spurious();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
